// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line refill on a miss.
// The refill takes one beat per word, in order, from main memory.
module instr_cache #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int SET_COUNT   = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_invalidate,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_hit,
  output logic                   o_stall,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_data
);

  localparam int IDX   = $clog2(SET_COUNT);
  localparam int WRD   = $clog2(BLOCK_WORDS);
  localparam int TAG_W = ADDR_WIDTH - IDX - WRD - 2;

  typedef enum logic [0:0] {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                 state_r;
  logic [SET_COUNT-1:0]   valid_r;
  logic [TAG_W-1:0]       tag_arr_r  [SET_COUNT];
  logic [INSTR_WIDTH-1:0] data_arr_r [SET_COUNT*BLOCK_WORDS];
  logic [WRD-1:0]         cnt_r;
  logic                   pend_inv_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [IDX-1:0]         fill_idx_r;

  logic [WRD-1:0]         word_s;
  logic [IDX-1:0]         idx_s;
  logic [TAG_W-1:0]       tag_s;
  logic                   hit_s;
  logic [INSTR_WIDTH-1:0] instr_s;
  logic                   last_beat_s;
  logic                   unused_s;

  assign word_s      = i_addr[WRD+1:2];
  assign idx_s       = i_addr[WRD+IDX+1:WRD+2];
  assign tag_s       = i_addr[ADDR_WIDTH-1:WRD+IDX+2];
  assign last_beat_s = i_mem_valid && (cnt_r == WRD'(BLOCK_WORDS - 1));
  assign unused_s    = ^i_addr[1:0];

  // Lookup: only an idle cache can hit, and a concurrent invalidate forces a miss
  always_comb begin
    hit_s   = 1'b0;
    instr_s = '0;
    if ((state_r == IDLE) && i_fetch_req && !i_invalidate &&
        valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s)) begin
      hit_s   = 1'b1;
      instr_s = data_arr_r[{idx_s, word_s}];
    end else begin
      hit_s   = 1'b0;
      instr_s = '0;
    end
  end

  assign o_hit         = hit_s;
  assign o_instruction = instr_s;
  assign o_stall       = i_fetch_req & ~hit_s;
  assign o_mem_req     = (state_r == REFILL);
  assign o_mem_addr    = mem_addr_r;

  // Control FSM: miss detection, beat counting, valid bits and deferred invalidation
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      cnt_r      <= '0;
      pend_inv_r <= 1'b0;
      mem_addr_r <= '0;
      fill_idx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          pend_inv_r <= 1'b0;
          if (i_invalidate) begin
            valid_r <= '0;
          end else if (i_fetch_req && !hit_s) begin
            mem_addr_r <= {i_addr[ADDR_WIDTH-1:WRD+2], (WRD+2)'(0)};
            fill_idx_r <= idx_s;
            cnt_r      <= '0;
            state_r    <= REFILL;
          end
        end
        REFILL: begin
          if (i_mem_valid) begin
            cnt_r <= cnt_r + WRD'(1);
          end
          // An invalidate seen at any point of the refill also kills the line being filled
          if (last_beat_s) begin
            state_r    <= IDLE;
            pend_inv_r <= 1'b0;
            if (pend_inv_r || i_invalidate) begin
              valid_r <= '0;
            end else begin
              valid_r[fill_idx_r] <= 1'b1;
            end
          end else if (i_invalidate) begin
            pend_inv_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage, written only by refill beats; intentionally not reset
  always_ff @(posedge i_clk) begin
    if ((state_r == REFILL) && i_mem_valid) begin
      data_arr_r[{fill_idx_r, cnt_r}] <= i_mem_data;
      if (last_beat_s) begin
        tag_arr_r[fill_idx_r] <= mem_addr_r[ADDR_WIDTH-1:WRD+IDX+2];
      end
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: a memory model feeds refills and a scoreboard queue
// holds the instructions expected on hits.
module tb_instr_cache;
  localparam int AW = 64;
  localparam int IW = 32;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic          i_fetch_req;
  logic [AW-1:0] i_addr;
  logic          i_invalidate;
  logic [IW-1:0] o_instruction;
  logic          o_hit;
  logic          o_stall;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_valid;
  logic [IW-1:0] i_mem_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [IW-1:0] model [logic [AW-1:0]];
  logic [IW-1:0] exp_q [$];

  instr_cache dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_fetch_req(i_fetch_req), .i_addr(i_addr),
    .i_invalidate(i_invalidate), .o_instruction(o_instruction), .o_hit(o_hit),
    .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One-cycle lookup; request is withdrawn before the edge so a miss starts no refill
  task automatic lookup(input logic [AW-1:0] a, input bit exp_hit);
    i_fetch_req = 1'b1;
    i_addr      = a;
    if (exp_hit) exp_q.push_back(model[{a[AW-1:2], 2'b00}]);
    #1;
    chk("hit", o_hit, exp_hit);
    chk("stall", o_stall, !exp_hit);
    if (exp_hit) chk("instr", o_instruction, exp_q.pop_front());
    else         chk("instr_zero", o_instruction, 64'd0);
    i_fetch_req = 1'b0;
    tick();
  endtask

  // Full miss + refill; optional idle gaps (with PC wiggle) and an invalidate at beat 3
  task automatic refill(input logic [AW-1:0] a, input logic [IW-1:0] dbase,
                        input bit gapped, input bit inv_mid);
    logic [AW-1:0] line;
    line        = {a[AW-1:5], 5'b00000};
    i_fetch_req = 1'b1;
    i_addr      = a;
    #1;
    chk("miss_stall", o_stall, 64'd1);
    chk("miss_hit", o_hit, 64'd0);
    chk("idle_memreq", o_mem_req, 64'd0);
    tick();
    chk("memreq_on", o_mem_req, 64'd1);
    chk("mem_addr", o_mem_addr, line);
    for (int w = 0; w < 8; w++) begin
      i_mem_valid  = 1'b1;
      i_mem_data   = dbase + IW'(w);
      model[line + AW'(4*w)] = dbase + IW'(w);
      i_invalidate = inv_mid && (w == 3);
      #1;
      chk("refill_memreq", o_mem_req, 64'd1);
      chk("refill_stall", o_stall, 64'd1);
      chk("refill_nohit", o_hit, 64'd0);
      tick();
      i_invalidate = 1'b0;
      i_mem_valid  = 1'b0;
      if (gapped && w < 7) begin
        i_addr     = a ^ 64'h0000_0000_0004_0000;
        i_mem_data = 32'hDEAD_BEEF;
        #1;
        chk("gap_addr", o_mem_addr, line);
        chk("gap_memreq", o_mem_req, 64'd1);
        tick();
        i_addr = a;
      end
    end
    i_mem_data = '0;
    #1;
    chk("memreq_off", o_mem_req, 64'd0);
    if (inv_mid) begin
      chk("post_inv_hit", o_hit, 64'd0);
    end else begin
      exp_q.push_back(model[{a[AW-1:2], 2'b00}]);
      chk("first_hit", o_hit, 64'd1);
      chk("first_instr", o_instruction, exp_q.pop_front());
    end
    i_fetch_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_arst = 1'b1; i_fetch_req = 1'b0; i_addr = '0; i_invalidate = 1'b0;
    i_mem_valid = 1'b0; i_mem_data = '0;
    #12;
    chk("rst_memreq", o_mem_req, 64'd0);
    chk("rst_memaddr", o_mem_addr, 64'd0);
    chk("rst_hit", o_hit, 64'd0);
    chk("rst_stall", o_stall, 64'd0);
    chk("rst_instr", o_instruction, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    tick();

    // Cold miss, then sweep: once with stray memory beats in IDLE, once clean
    refill(64'h1004, 32'hA0, 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int w = 0; w < 8; w++) begin
        i_mem_valid = (pass == 0);
        i_mem_data  = 32'h5555_0000 + 32'(w);
        lookup(64'h1000 + 64'(4*w), 1'b1);
        chk("sweep_memreq", o_mem_req, 64'd0);
      end
    end
    i_mem_valid = 1'b0;
    i_mem_data  = '0;

    // Conflict eviction, then gapped refill of the original line with PC wiggle
    refill(64'h1200, 32'hB0, 1'b0, 1'b0);
    lookup(64'h1000, 1'b0);
    refill(64'h1008, 32'hC0, 1'b1, 1'b0);
    for (int w = 0; w < 8; w++) lookup(64'h1000 + 64'(4*w), 1'b1);
    lookup(64'h1204, 1'b0);

    // Invalidate in IDLE forces a miss that cycle and starts no refill
    lookup(64'h1010, 1'b1);
    i_fetch_req  = 1'b1;
    i_addr       = 64'h1000;
    i_invalidate = 1'b1;
    #1;
    chk("inv_hit", o_hit, 64'd0);
    chk("inv_instr", o_instruction, 64'd0);
    tick();
    i_fetch_req  = 1'b0;
    i_invalidate = 1'b0;
    chk("inv_no_refill", o_mem_req, 64'd0);
    tick();
    lookup(64'h1000, 1'b0);
    // Invalidate mid-refill leaves the just-filled line invalid
    refill(64'h1000, 32'hD0, 1'b0, 1'b1);
    lookup(64'h1000, 1'b0);
    lookup(64'h101C, 1'b0);

    // Reset after 3 beats aborts the refill
    refill(64'h1000, 32'hF0, 1'b0, 1'b0);
    i_fetch_req = 1'b1;
    i_addr      = 64'h3000;
    tick();
    i_fetch_req = 1'b0;
    for (int w = 0; w < 3; w++) begin
      i_mem_valid = 1'b1;
      i_mem_data  = 32'hE0 + 32'(w);
      tick();
    end
    i_mem_valid = 1'b0;
    chk("pre_rst_memreq", o_mem_req, 64'd1);
    #2;
    i_arst = 1'b1;
    #1;
    chk("async_rst_memreq", o_mem_req, 64'd0);
    chk("async_rst_memaddr", o_mem_addr, 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    tick();
    lookup(64'h3000, 1'b0);
    lookup(64'h1000, 1'b0);
    refill(64'h3004, 32'h70, 1'b0, 1'b0);
    lookup(64'h301C, 1'b1);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
